// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multicycle ALU: operand width, opcode encoding,
// controller states and the single-cycle datapath function.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // MUL is not handled here; it goes through the iterative multiplier.
    function automatic logic [XLEN-1:0] alu_compute(
        input alu_op_e         op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        logic [4:0]      shamt;
        shamt = b[4:0];
        res   = '0;
        unique case (op)
            ALU_AND:  res = a & b;
            ALU_XOR:  res = a ^ b;
            ALU_SLL:  res = a << shamt;
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_ADDI: res = a + b;
            ALU_SRAI: res = $unsigned($signed(a) >>> shamt);
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operation/result bus of the multicycle ALU; master drives operations,
// slave (the ALU) returns handshake and result.
interface multicycle_alu_if #(
    parameter int XLEN = alu_pkg::XLEN
);
    logic            valid_i;
    logic [2:0]      ALUCtrl_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] data_o;
    logic            busy_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  ready_o, valid_o, data_o, busy_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/multicycle_alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// done_o is asserted during the last iteration with the final product on product_o.
module mul_seq
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::XLEN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] product_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // Product includes the final partial term being added this cycle.
    assign done_o    = active_q && (cnt_q == CNT_LAST);
    assign product_o = acc_d;

endmodule

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/add/shift ops and a 32-cycle iterative multiply.
// Results are registered; valid_o pulses one cycle after completion.
//
//   state   | meaning
//   IDLE    | ready for a new op; non-MUL ops complete here in one cycle
//   MUL     | multiplier iterating; inputs ignored until its last cycle
module multicycle_alu #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multicycle_alu_if.slave     bus
);
    import alu_pkg::*;

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    alu_op_e         op;

    assign op = alu_op_e'(bus.ALUCtrl_i);

    mul_seq #(.W(XLEN)) u_mul_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (bus.data1_i),
        .b_i       (bus.data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    if (op == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        data_d  = alu_compute(op, bus.data1_i, bus.data2_i);
                        valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    data_d  = mul_product;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench: directed corner cases plus randomized traffic against
// a cycle-count reference model of the multicycle ALU.
module tb_multicycle_alu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_alu_if #(.XLEN(32)) bus ();

    multicycle_alu #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          mul_left  = 0;
    logic [31:0] mul_res   = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data  = '0;
    bit          model_ok  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        int          sh;
        sh = int'(b % 32);
        case (op)
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return a * (32'd1 << sh);
            3'd3: return a + b;
            3'd4: return a - b;
            3'd5: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
            3'd6: return a + b;
            default: return 32'($signed(a) / (64'sd1 <<< sh) -
                                (($signed(a) < 0 && ($signed(a) % (64'sd1 <<< sh)) != 0) ? 1 : 0));
        endcase
    endfunction

    // One clock: check outputs at negedge, drive inputs, advance the model for the next edge.
    task automatic cycle(input logic r, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (model_ok) begin
            check("ready_o", 32'(bus.ready_o), 32'(mul_left == 0));
            check("busy_o",  32'(bus.busy_o),  32'(mul_left != 0));
            check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
            check("data_o",  bus.data_o, exp_data);
        end
        rst           = r;
        bus.valid_i   = v;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        if (r) begin
            mul_left  = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
            model_ok  = 1'b1;
        end else if (mul_left > 0) begin
            mul_left--;
            exp_valid = (mul_left == 0);
            if (mul_left == 0) exp_data = mul_res;
        end else if (v && op == 3'd5) begin
            mul_left  = 32;
            mul_res   = ref_alu(op, a, b);
            exp_valid = 1'b0;
        end else if (v) begin
            exp_data  = ref_alu(op, a, b);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [31:0] val);
        @(posedge clk);
        #1;
        check(tag, bus.data_o, val);
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.ALUCtrl_i = '0; bus.data1_i = '0; bus.data2_i = '0;
        cycle(1'b1, 1'b1, 3'd3, 32'h1, 32'h1);
        cycle(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        idle();

        cycle(1'b0, 1'b1, 3'd3, 32'h7FFFFFFF, 32'h1);   peek("add_ovf",  32'h80000000);
        cycle(1'b0, 1'b1, 3'd4, 32'h0, 32'h1);          peek("sub_neg",  32'hFFFFFFFF);
        cycle(1'b0, 1'b1, 3'd7, 32'h80000000, 32'h24);  peek("srai",     32'hF8000000);
        cycle(1'b0, 1'b1, 3'd2, 32'h1, 32'd31);         peek("sll31",    32'h80000000);
        idle(); idle();

        cycle(1'b0, 1'b1, 3'd5, 32'hFFFFFFFF, 32'h3);
        repeat (32) idle();
        peek("mul_m1x3", 32'hFFFFFFFD);
        cycle(1'b0, 1'b1, 3'd5, 32'h10000, 32'h10000);
        repeat (32) idle();
        peek("mul_wrap", 32'h0);
        idle();

        cycle(1'b0, 1'b1, 3'd5, 32'd1234567, 32'd89);
        repeat (33) cycle(1'b0, 1'b1, 3'd3, 32'd5, 32'd6);
        peek("add_b2b", 32'd11);
        idle(); idle();

        cycle(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 32'h1234);
        repeat (10) idle();
        cycle(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        idle();
        check("rst_abort_data", bus.data_o, 32'h0);
        cycle(1'b0, 1'b1, 3'd0, 32'hF0F0, 32'hFF00);    peek("and_after_rst", 32'hF000);

        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 3'd1, 32'hA5A5_0000 + 32'(i), 32'h0F0F_1111 * 32'(i + 1));
        idle(); idle();

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
                  3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        repeat (34) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width; only 32 is supported.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  an operation is presented this cycle.
REQ-005 SHALL have port ALUCtrl_i  input  3  operation code from ALU control.
REQ-006 SHALL have port data1_i  input  XLEN  operand 1 (rs1).
REQ-007 SHALL have port data2_i  input  XLEN  operand 2 (rs2 or sign-extended immediate).
REQ-008 SHALL have port ready_o  output  1  block can accept an operation this cycle.
REQ-009 SHALL have port valid_o  output  1  data_o carries a new result this cycle (single-cycle pulse).
REQ-010 SHALL have port data_o  output  XLEN  registered result.
REQ-011 SHALL have port busy_o  output  1  equals NOT ready_o; drives pipeline stall.

Function
REQ-012 SHALL decode ALUCtrl_i as: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 ADDI (add), 111 SRAI (arithmetic right shift).
REQ-013 SHALL use data2_i[4:0] as the shift amount for SLL and SRAI; upper bits ignored.
REQ-014 SHALL compute ADD, ADDI, SUB and MUL modulo 2^32; MUL returns the low 32 bits of the product; no overflow flag.
REQ-015 SHALL accept an operation only on a rising edge where valid_i=1 and ready_o=1; valid_i while ready_o=0 is ignored and no state changes.
REQ-016 SHALL implement FSM states IDLE and MUL; ready_o=1 only in IDLE.
REQ-017 In IDLE, on acceptance of a non-MUL op, SHALL register the result into data_o and pulse valid_o in the next cycle; state stays IDLE (latency 1, throughput 1/cycle).
REQ-018 In IDLE, on acceptance of MUL, SHALL latch both operands, clear a 5-bit iteration counter, clear the accumulator and move to MUL.
REQ-019 In MUL, SHALL process one multiplier bit per cycle (shift-add, LSB first) for exactly 32 cycles, ignoring valid_i and operand changes.
REQ-020 On the 32nd MUL cycle (counter=31), SHALL write the product to data_o, pulse valid_o in the next cycle and return to IDLE; MUL latency is 32 cycles from the accepting edge.
REQ-021 SHALL hold ready_o high in the cycle valid_o pulses for a MUL result, so a new op may be accepted back-to-back.
REQ-022 SHALL hold data_o stable between valid_o pulses.
REQ-023 SHALL never assert valid_o for more than one cycle per accepted op, nor without a preceding acceptance.

Reset
REQ-024 While rst_i=1 at a rising edge, SHALL force state IDLE, counter 0, accumulator 0, data_o=0, valid_o=0; ready_o=1 and busy_o=0 in the following cycle.
REQ-025 Reset asserted during MUL SHALL abort the multiply with no valid_o pulse.
REQ-026 valid_i coincident with rst_i SHALL be discarded.

Structure
REQ-027 The ALUCtrl encodings, XLEN and MUL_CYCLES=32 SHALL live in shared package alu_pkg.
REQ-028 The iterative multiplier (operand latch, accumulator, counter) SHALL be a sub-module mul_seq with start/done handshake; the FSM and single-cycle ops stay in multicycle_alu.

Verification
REQ-029 ADD 0x7FFFFFFF + 0x00000001 -> valid_o 1 cycle later, data_o=0x80000000; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-030 SRAI 0x80000000 by data2_i=0x00000024 (shamt 4) -> 0xF8000000; SLL 0x1 by 31 -> 0x80000000.
REQ-031 MUL 0xFFFFFFFF * 0x00000003 -> ready_o low 32 cycles, valid_o after 32 cycles, data_o=0xFFFFFFFD; MUL 0x10000 * 0x10000 -> 0x00000000.
REQ-032 MUL accepted, then ADD 5+6 presented with valid_i=1 continuously -> ADD accepted in the cycle MUL valid_o pulses, data_o=11 on the next cycle.
REQ-033 rst_i pulsed at MUL cycle 10 -> no valid_o, data_o=0, ready_o=1 next cycle; subsequent AND 0xF0F0 & 0xFF00 -> 0xF000.
REQ-034 Back-to-back XOR ops on 4 consecutive cycles -> 4 consecutive valid_o pulses with correct results, ready_o never low.
